cmdsend: RTL and testbench
==========================

// Module: cmdsend
// PURPOSE
//  Command-packet transmitter, the sending end of the command channel. On request, builds one
//  Ethernet/IPv4/UDP frame (dst port 3776, magic word, 4 fwd-port bytes + mode byte) and writes
//  it byte-wise into a 9-bit TX-FIFO. Sits between local control logic and the TX MAC FIFO.
// PARAMETERS
//  MAGIC_CODE 32'hC0C0C0CC      magic word at frame bytes 42..45
//  DST_MAC    48'hFFFFFFFFFFFF  Ethernet destination
//  SRC_MAC    48'h001122334455  Ethernet source
//  SRC_IP     32'h0A000001      IPv4 source (10.0.0.1)
//  DST_IP     32'h0A0000FF      IPv4 destination (10.0.0.255)
//  UDP_SPORT  16'd3776          UDP source port
//  TTL        8'h40             IPv4 time-to-live
// PORTS
//  sys_clk       in   1   single clock; all logic on posedge
//  sys_rst       in   1   synchronous, active-high reset
//  cmd_req       in   1   start-frame request; sampled only in IDLE
//  cmd_fwd_port  in   16  four 4-bit port fields, snapshotted on accept
//  cmd_mode      in   1   bonding-mode bit, snapshotted on accept
//  cmd_busy      out  1   high in every state except IDLE
//  cmd_done      out  1   1-cycle pulse after the delimiter word of a frame is written
//  tx_din        out  9   [8]=frame-byte flag (1 in frame, 0 for delimiter), [7:0]=data
//  tx_full       in   1   TX-FIFO full
//  tx_wr_en      out  1   FIFO write strobe; never high while tx_full=1
// BEHAVIOUR
//  Reset: tx_wr_en=0, tx_din=0, cmd_done=0, cmd_busy=1, state=INIT, ip_id=0, snapshot regs=0.
//  Write rule: a word is written in a cycle with tx_wr_en=1 (implies tx_full=0). Byte counter
//   (6 bit) advances only on a write; tx_full stalls with tx_din held, no byte skipped/repeated.
//  FSM: INIT  -> write delimiter 9'h000 -> IDLE (clears any partial frame left in FIFO by reset).
//       IDLE  -> cmd_req=1: snapshot inputs, -> CSUM (or SEND if macro off). cmd_req ignored
//                (not queued) in all other states.
//       CSUM  -> 10 cycles summing header words, 2 fold cycles -> SEND.
//       SEND  -> bytes 0..59 with [8]=1; after byte 59 -> GAP.
//       GAP   -> write delimiter 9'h000; pulse cmd_done; ip_id<=ip_id+1 (wraps FFFF->0000); IDLE.
//  Latency (macro off, tx_full=0): req in cycle N -> byte 0 written cycle N+1, done pulse N+62.
//  Frame layout (byte offsets, big-endian fields):
//   0-5 DST_MAC | 6-11 SRC_MAC | 12-13 0x0800 | 14-15 0x4500 | 16-17 total len 0x002E
//   18-19 ip_id | 20-21 0x0000 | 22 TTL | 23 0x11 | 24-25 IP checksum | 26-29 SRC_IP
//   30-33 DST_IP | 34-35 UDP_SPORT | 36-37 0x0EC0 (3776) | 38-39 UDP len 0x001A | 40-41 0x0000
//   42-45 MAGIC_CODE | 46-49 {4'h0,fwd[3:0]},{4'h0,fwd[7:4]},{4'h0,fwd[11:8]},{4'h0,fwd[15:12]}
//   50 {7'b0,mode} | 51-59 0x00 pad (60 bytes total; FCS appended by MAC).
//  Mid-frame sys_rst: abort immediately, tx_wr_en=0 same edge; INIT re-delimits the FIFO.
// CONFIGURATION
//  CMDSEND_IPCSUM_EN defined: CSUM state active; bytes 24-25 = ones'-complement of the
//   ones'-complement 16-bit sum of header words (checksum field taken as 0), end-around carry.
//  Not defined: CSUM state removed, bytes 24-25 = 0x0000, checksum logic not synthesised.
// STRUCTURE
//  Shared header cmd_defs.vh: CMD_UDP_PORT 16'd3776, ETHTYPE_IPV4, IPV4_VER_IHL 16'h4500,
//   IPPROTO_UDP 8'h11, CMD_FRAME_LEN 60, field offsets 42 (magic) / 46 (payload) / 50 (mode),
//   FSM state encodings; the command receiver takes its offsets from the same file.
//  One sub-module: cmdsend_csum (20-bit accumulator, word input + valid, clear, fold, 16-bit out).
// TESTING
//  T1 reset release, tx_full=0 -> exactly one 9'h000 write, then cmd_busy=0, no further writes.
//  T2 cmd_req, fwd=16'h7888, mode=1, macro off -> 60 bytes [8]=1, bytes 46..50 = 08 08 08 07 01,
//     36-37 = 0E C0, 42-45 = C0 C0 C0 CC, 24-25 = 00 00, then 9'h000, cmd_done one cycle.
//  T3 macro on, defaults, ip_id=0 -> bytes 24-25 = 65 C0; second frame has ip_id=0001, csum 65 BF.
//  T4 tx_full toggled pseudo-randomly during SEND -> no write while full, byte stream identical to T2.
//  T5 cmd_req held high and fwd changed mid-frame -> frame uses accept-time snapshot; next frame
//     starts only after cmd_done, with new values.
//  T6 sys_rst at byte 30 -> tx_wr_en low next cycle, INIT delimiter, then clean full frame on request;
//     loopback into the command receiver decodes fwd/mode correctly.

Source files
------------

// File: rtl/cmdsend_pkg.sv
// cmdsend_pkg: constants and types shared by the command-channel transmitter and
// its receiver. It holds the protocol constants, the frame field offsets, the FSM
// state encoding and the accept-time snapshot record.
// Build option: CMDSEND_IPCSUM_EN (see cmdsend.sv) enables the IPv4 header checksum.
package cmdsend_pkg;

  localparam logic [15:0] CMD_UDP_PORT = 16'd3776;
  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] IPV4_VER_IHL = 16'h4500;
  localparam logic [15:0] IPV4_TOT_LEN = 16'h002E;
  localparam logic [15:0] UDP_LEN      = 16'h001A;
  localparam logic [7:0]  IPPROTO_UDP  = 8'h11;

  localparam int CMD_FRAME_LEN = 60;
  localparam int OFF_CSUM      = 24;
  localparam int OFF_MAGIC     = 42;
  localparam int OFF_PAYLOAD   = 46;
  localparam int OFF_MODE      = 50;

  // IPv4 header = 10 words starting at frame word 7 (byte 14)
  localparam int CSUM_WORDS    = 10;
  localparam int CSUM_FIRST_W  = OFF_CSUM / 2 - 5;

  localparam logic [8:0] DELIM = 9'h000;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_CSUM = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] fwd;
    logic        mode;
  } cmd_snap_t;

endpackage

// File: rtl/cmdsend_csum.sv
// cmdsend_csum: ones'-complement header checksum accumulator.
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   clr               zero the accumulator (takes priority over vld/fold)
//   vld, word         add a 16-bit header word
//   fold              add the carry nibble back into the low 16 bits
//   sum               inverted low 16 bits = checksum once folding is done
// The 20-bit width covers ten words of 16'hFFFF. Two folds always settle:
// the first leaves at most one carry, and the second absorbs it.
module cmdsend_csum (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        clr,
  input  logic        vld,
  input  logic [15:0] word,
  input  logic        fold,
  output logic [15:0] sum
);

  logic [19:0] acc;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr)
      acc <= '0;
    else if (vld)
      acc <= acc + {4'h0, word};
    else if (fold)
      acc <= {4'h0, acc[15:0]} + {16'h0, acc[19:16]};
  end

  assign sum = ~acc[15:0];

endmodule

// File: rtl/cmdsend.sv
// cmdsend: command-packet transmitter. On cmd_req it builds one 60-byte
// Ethernet/IPv4/UDP frame and streams it into a 9-bit TX FIFO. It then writes
// a 9'h000 delimiter word.
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   cmd_req              start request, sampled only in IDLE
//   cmd_fwd_port, cmd_mode  payload fields, captured when a request is accepted
//   cmd_busy             high in every state except IDLE
//   cmd_done             one-cycle pulse after the delimiter word is written
//   tx_din               {frame flag, data byte}
//   tx_full, tx_wr_en    FIFO handshake; a word is written when tx_wr_en=1
// Build option CMDSEND_IPCSUM_EN: adds a CSUM phase (10 sum cycles + 2 fold cycles)
// and fills in the IPv4 checksum. Without it, bytes 24-25 are 0x0000.
module cmdsend
  import cmdsend_pkg::*;
#(
  parameter logic [31:0] MAGIC_CODE = 32'hC0C0C0CC,
  parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC    = 48'h001122334455,
  parameter logic [31:0] SRC_IP     = 32'h0A000001,
  parameter logic [31:0] DST_IP     = 32'h0A0000FF,
  parameter logic [15:0] UDP_SPORT  = 16'd3776,
  parameter logic [7:0]  TTL        = 8'h40
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_req,
  input  logic [15:0] cmd_fwd_port,
  input  logic        cmd_mode,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [8:0]  tx_din,
  input  logic        tx_full,
  output logic        tx_wr_en
);

  state_t      state;
  logic [5:0]  byte_cnt;
  logic        pend;       // tx_din holds a word that still has to be written
  logic [15:0] ip_id;
  cmd_snap_t   snap;
  logic [15:0] csum_val;
  logic [7:0]  nxt_byte;
  logic        wr;

  // 16-bit frame word at word index w (frame byte 2*w is the high byte)
  function automatic logic [15:0] word_at(input logic [4:0] w, input logic [15:0] ck,
                                          input logic [15:0] id, input cmd_snap_t s);
    logic [15:0] r;
    r = 16'h0000;
    case (w)
      5'd0:  r = DST_MAC[47:32];
      5'd1:  r = DST_MAC[31:16];
      5'd2:  r = DST_MAC[15:0];
      5'd3:  r = SRC_MAC[47:32];
      5'd4:  r = SRC_MAC[31:16];
      5'd5:  r = SRC_MAC[15:0];
      5'd6:  r = ETHTYPE_IPV4;
      5'd7:  r = IPV4_VER_IHL;
      5'd8:  r = IPV4_TOT_LEN;
      5'd9:  r = id;
      5'd11: r = {TTL, IPPROTO_UDP};
      5'd12: r = ck;
      5'd13: r = SRC_IP[31:16];
      5'd14: r = SRC_IP[15:0];
      5'd15: r = DST_IP[31:16];
      5'd16: r = DST_IP[15:0];
      5'd17: r = UDP_SPORT;
      5'd18: r = CMD_UDP_PORT;
      5'd19: r = UDP_LEN;
      5'd21: r = MAGIC_CODE[31:16];
      5'd22: r = MAGIC_CODE[15:0];
      5'd23: r = {4'h0, s.fwd[3:0], 4'h0, s.fwd[7:4]};
      5'd24: r = {4'h0, s.fwd[11:8], 4'h0, s.fwd[15:12]};
      5'd25: r = {7'b0, s.mode, 8'h00};
      default: r = 16'h0000;  // flags/frag, UDP csum, padding
    endcase
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [15:0] ck,
                                            input logic [15:0] id, input cmd_snap_t s);
    logic [15:0] w;
    w = word_at(idx[5:1], ck, id, s);
    return idx[0] ? w[7:0] : w[15:8];
  endfunction

  // Gating with tx_full here keeps writes off a full FIFO without a cycle of delay.
  assign tx_wr_en = pend & ~tx_full;
  assign wr       = tx_wr_en;

  always_comb nxt_byte = frame_byte(byte_cnt + 6'd1, csum_val, ip_id, snap);

`ifdef CMDSEND_IPCSUM_EN
  logic [3:0]  csum_cnt;
  logic [15:0] csum_word;

  assign csum_word = word_at(5'(CSUM_FIRST_W) + {1'b0, csum_cnt}, 16'h0000, ip_id, snap);

  cmdsend_csum u_csum (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (state == ST_IDLE && cmd_req),
    .vld     (state == ST_CSUM && csum_cnt <  4'(CSUM_WORDS)),
    .word    (csum_word),
    .fold    (state == ST_CSUM && csum_cnt >= 4'(CSUM_WORDS)),
    .sum     (csum_val)
  );
`else
  assign csum_val = 16'h0000;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_INIT;
      pend     <= 1'b0;
      tx_din   <= 9'h000;
      cmd_done <= 1'b0;
      cmd_busy <= 1'b1;
      ip_id    <= 16'h0000;
      snap     <= '0;
      byte_cnt <= 6'd0;
`ifdef CMDSEND_IPCSUM_EN
      csum_cnt <= 4'd0;
`endif
    end else begin
      cmd_done <= 1'b0;
      case (state)
        // A delimiter closes off any partial frame a reset left in the FIFO.
        ST_INIT: begin
          if (!pend) begin
            pend   <= 1'b1;
            tx_din <= DELIM;
          end else if (wr) begin
            pend     <= 1'b0;
            cmd_busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cmd_req) begin
            snap     <= '{fwd: cmd_fwd_port, mode: cmd_mode};
            cmd_busy <= 1'b1;
            byte_cnt <= 6'd0;
`ifdef CMDSEND_IPCSUM_EN
            csum_cnt <= 4'd0;
            state    <= ST_CSUM;
`else
            pend     <= 1'b1;
            tx_din   <= {1'b1, frame_byte(6'd0, csum_val, ip_id, snap)};
            state    <= ST_SEND;
`endif
          end
        end
`ifdef CMDSEND_IPCSUM_EN
        ST_CSUM: begin
          csum_cnt <= csum_cnt + 4'd1;
          if (csum_cnt == 4'(CSUM_WORDS + 1)) begin
            pend   <= 1'b1;
            tx_din <= {1'b1, frame_byte(6'd0, csum_val, ip_id, snap)};
            state  <= ST_SEND;
          end
        end
`endif
        ST_SEND: begin
          if (wr) begin
            if (byte_cnt == 6'(CMD_FRAME_LEN - 1)) begin
              tx_din <= DELIM;
              state  <= ST_GAP;
            end else begin
              byte_cnt <= byte_cnt + 6'd1;
              tx_din   <= {1'b1, nxt_byte};
            end
          end
        end
        ST_GAP: begin
          if (wr) begin
            pend     <= 1'b0;
            cmd_done <= 1'b1;
            cmd_busy <= 1'b0;
            ip_id    <= ip_id + 16'd1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cmdsend.sv
// tb_cmdsend: bench for the command-frame transmitter. Expected frames come
// from a flat field-by-field image of the frame layout; the IPv4 checksum is
// computed arithmetically. FIFO writes are captured by a monitor.
module tb_cmdsend;

  logic        sys_clk = 1'b0;
  logic        sys_rst, cmd_req, cmd_mode, tx_full;
  logic [15:0] cmd_fwd_port;
  logic        cmd_busy, cmd_done, tx_wr_en;
  logic [8:0]  tx_din;

  cmdsend dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_req(cmd_req),
    .cmd_fwd_port(cmd_fwd_port), .cmd_mode(cmd_mode), .cmd_busy(cmd_busy),
    .cmd_done(cmd_done), .tx_din(tx_din), .tx_full(tx_full), .tx_wr_en(tx_wr_en)
  );

  always #5 sys_clk = ~sys_clk;

`ifdef CMDSEND_IPCSUM_EN
  localparam int LAT0 = 13;
  localparam logic [15:0] CK_ID0 = 16'h65C0;
  localparam logic [15:0] CK_ID1 = 16'h65BF;
`else
  localparam int LAT0 = 1;
  localparam logic [15:0] CK_ID0 = 16'h0000;
  localparam logic [15:0] CK_ID1 = 16'h0000;
`endif
  localparam int LATD = LAT0 + 61;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit full_en = 1'b0;
  logic [15:0] exp_ipid = 16'h0;
  logic [8:0]  cap_q[$];
  int          wr_cyc_q[$], done_q[$];
  logic        busy_q[$];

  typedef struct {
    logic [15:0] fwd;
    logic        mode;
    bit          rnd_full;
    logic [39:0] pl;       // expected bytes 46..50
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [479:0] exp_frame(input logic [15:0] fwd, input logic mode,
                                             input logic [15:0] ipid);
    logic [479:0] f;
`ifdef CMDSEND_IPCSUM_EN
    int s;
`endif
    f = {48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 16'h4500, 16'h002E, ipid,
         16'h0000, 8'h40, 8'h11, 16'h0000, 32'h0A000001, 32'h0A0000FF,
         16'd3776, 16'd3776, 16'h001A, 16'h0000, 32'hC0C0C0CC,
         4'h0, fwd[3:0], 4'h0, fwd[7:4], 4'h0, fwd[11:8], 4'h0, fwd[15:12],
         7'b0, mode, 72'h0};
`ifdef CMDSEND_IPCSUM_EN
    s = 0;
    for (int j = 14; j < 34; j += 2) s += int'(f[479-8*j -: 16]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    f[479-8*24 -: 16] = ~s[15:0];
`endif
    return f;
  endfunction

  // clock-cycle counter, tx_full driver, write/done monitor
  initial forever begin @(posedge sys_clk); cyc++; end
  initial forever begin
    @(posedge sys_clk); #1;
    tx_full = full_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  initial forever begin
    @(negedge sys_clk);
    if (tx_wr_en) begin cap_q.push_back(tx_din); wr_cyc_q.push_back(cyc); end
    if (cmd_done) begin done_q.push_back(cyc); busy_q.push_back(cmd_busy); end
    if (tx_full) begin
      n_cmp++;
      if (tx_wr_en) begin n_fail++; $display("FAIL wr_while_full: got 1 expected 0"); end
    end
  end

  task automatic clr_caps();
    cap_q.delete(); wr_cyc_q.delete(); done_q.delete(); busy_q.delete();
  endtask

  task automatic wait_done(input int n, input string nm);
    int k = 0;
    while (done_q.size() < n && k < 3000) begin @(negedge sys_clk); #1; k++; end
    chk({nm, " done_seen"}, 64'(done_q.size() >= n), 1);
  endtask

  task automatic check_frame(input int base, input logic [15:0] fwd, input logic mode,
                             input logic [15:0] ipid, input string nm);
    logic [479:0] f;
    f = exp_frame(fwd, mode, ipid);
    chk({nm, " len"}, 64'(cap_q.size() >= base + 61), 1);
    if (cap_q.size() < base + 61) return;
    for (int i = 0; i < 60; i++)
      chk($sformatf("%s byte%0d", nm, i), cap_q[base+i], {1'b1, f[479-8*i -: 8]});
    chk({nm, " delim"}, cap_q[base+60], 9'h000);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int rc;
    clr_caps();
    full_en = v.rnd_full;
    @(posedge sys_clk); #1;
    cmd_fwd_port = v.fwd; cmd_mode = v.mode; cmd_req = 1'b1; rc = cyc;
    @(posedge sys_clk); #1;
    // scramble inputs after accept: the frame must use the snapshot
    cmd_req = 1'b0; cmd_fwd_port = 16'($urandom); cmd_mode = 1'($urandom);
    wait_done(1, nm);
    repeat (4) @(posedge sys_clk);
    full_en = 1'b0;
    @(negedge sys_clk);
    chk({nm, " done_count"}, done_q.size(), 1);
    check_frame(0, v.fwd, v.mode, exp_ipid, nm);
    if (cap_q.size() >= 61 && done_q.size() >= 1) begin
      chk({nm, " payload"}, {cap_q[46][7:0], cap_q[47][7:0], cap_q[48][7:0],
                             cap_q[49][7:0], cap_q[50][7:0]}, v.pl);
      chk({nm, " done_after_delim"}, done_q[0], wr_cyc_q[60] + 1);
      chk({nm, " busy_at_done"}, busy_q[0], 0);
      if (!v.rnd_full) begin
        chk({nm, " lat_byte0"}, wr_cyc_q[0], rc + LAT0);
        chk({nm, " lat_done"}, done_q[0], rc + LATD);
      end
    end
    exp_ipid++;
  endtask

  vec_t tbl[6];

  initial begin
    int k;
    vec_t rv;
    tbl[0] = '{16'h7888, 1'b1, 1'b0, 40'h08_08_08_07_01};
    tbl[1] = '{16'h0000, 1'b0, 1'b0, 40'h00_00_00_00_00};
    tbl[2] = '{16'hFFFF, 1'b1, 1'b0, 40'h0F_0F_0F_0F_01};
    tbl[3] = '{16'h1234, 1'b0, 1'b0, 40'h04_03_02_01_00};
    tbl[4] = '{16'h7888, 1'b1, 1'b1, 40'h08_08_08_07_01};
    tbl[5] = '{16'hA5C3, 1'b0, 1'b1, 40'h03_0C_05_0A_00};

    sys_rst = 1'b1; cmd_req = 1'b0; cmd_fwd_port = 16'h0; cmd_mode = 1'b0; tx_full = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst wr_en", tx_wr_en, 0);
    chk("rst din", tx_din, 0);
    chk("rst done", cmd_done, 0);
    chk("rst busy", cmd_busy, 1);

    // reset release: exactly one delimiter, then idle
    clr_caps();
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("init writes", cap_q.size(), 1);
    if (cap_q.size() >= 1) chk("init delim", cap_q[0], 9'h000);
    chk("init busy", cmd_busy, 0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      rv.fwd = 16'($urandom); rv.mode = 1'($urandom); rv.rnd_full = 1'($urandom);
      rv.pl = {4'h0, rv.fwd[3:0], 4'h0, rv.fwd[7:4], 4'h0, rv.fwd[11:8],
               4'h0, rv.fwd[15:12], 7'b0, rv.mode};
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    // request held high, inputs changed mid-frame
    clr_caps();
    @(posedge sys_clk); #1;
    cmd_fwd_port = 16'h3C5A; cmd_mode = 1'b0; cmd_req = 1'b1;
    k = 0;
    while (cap_q.size() < 2 && k < 200) begin @(negedge sys_clk); #1; k++; end
    cmd_fwd_port = 16'hE17B; cmd_mode = 1'b1;
    k = 0;
    while (done_q.size() < 1 && k < 300) begin @(negedge sys_clk); #1; k++; end
    @(posedge sys_clk); #1 cmd_req = 1'b0;
    wait_done(2, "hold");
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("hold done_count", done_q.size(), 2);
    check_frame(0, 16'h3C5A, 1'b0, exp_ipid, "hold f1");
    check_frame(61, 16'hE17B, 1'b1, exp_ipid + 16'd1, "hold f2");
    if (wr_cyc_q.size() >= 62 && done_q.size() >= 1)
      chk("hold f2_after_done", 64'(wr_cyc_q[61] > done_q[0]), 1);
    exp_ipid += 16'd2;

    // reset partway through a frame
    clr_caps();
    @(posedge sys_clk); #1;
    cmd_fwd_port = 16'h4D2E; cmd_mode = 1'b1; cmd_req = 1'b1;
    @(posedge sys_clk); #1 cmd_req = 1'b0;
    k = 0;
    while (cap_q.size() < 30 && k < 200) begin @(negedge sys_clk); #1; k++; end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort wr_en", tx_wr_en, 0);
    chk("abort busy", cmd_busy, 1);
    chk("abort bytes", cap_q.size(), 30);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    clr_caps();
    exp_ipid = 16'h0;
    repeat (6) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reinit writes", cap_q.size(), 1);
    if (cap_q.size() >= 1) chk("reinit delim", cap_q[0], 9'h000);
    chk("reinit busy", cmd_busy, 0);

    rv = '{16'h4D2E, 1'b1, 1'b0, 40'h0E_02_0D_04_01};
    run_frame(rv, "post_rst0");
    if (cap_q.size() >= 61) begin
      chk("decode fwd", {cap_q[49][3:0], cap_q[48][3:0], cap_q[47][3:0], cap_q[46][3:0]},
          16'h4D2E);
      chk("decode mode", cap_q[50][0], 1);
      chk("ipid0 csum", {cap_q[24][7:0], cap_q[25][7:0]}, CK_ID0);
    end
    run_frame(rv, "post_rst1");
    if (cap_q.size() >= 61) chk("ipid1 csum", {cap_q[24][7:0], cap_q[25][7:0]}, CK_ID1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
